// File: rtl/top_arbiter_pkg.sv
// Shared types and constants for the two-device arbiter: FSM state codes,
// device ids, default service lengths and the counter-width helper.
package top_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SERV1 = 2'd1;
    localparam logic [1:0] ST_SERV2 = 2'd2;

    typedef logic dev_id_t;
    localparam dev_id_t DEV_1 = 1'b0;
    localparam dev_id_t DEV_2 = 1'b1;

    localparam int unsigned DEF_DEV1_CYCLES = 4;
    localparam int unsigned DEF_DEV2_CYCLES = 6;
    localparam int unsigned COLL_W          = 16;

    // Width of the service down-counter: clog2 of the longer service, at least 1.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        if (m <= 32'd1) return 32'd1;
        return 32'($clog2(m));
    endfunction

endpackage

// File: rtl/top_arbiter_req.sv
// Per-device request front end: accepts a request into a single pending slot,
// rejects it (drop pulse) when busy or disabled, and clears on disable or grant.
module top_arbiter_req (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic req_i,
    input  logic granted_i,
    input  logic take_i,
    output logic pending_o,
    output logic drop_o
);

    logic pending_q, pending_d;
    logic drop_q, drop_d;

    always_comb begin
        drop_d    = req_i & (~en_i | pending_q | granted_i);
        pending_d = pending_q & en_i;
        if (req_i & en_i & ~pending_q & ~granted_i) pending_d = 1'b1;
        if (take_i) pending_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            drop_q    <= drop_d;
        end
    end

    assign pending_o = pending_q;
    assign drop_o    = drop_q;

endmodule

// File: rtl/top_arbiter.sv
// Two-device shared-resource arbiter with alternating tie-break and fixed
// per-device service length. Optional contention counter: TOP_ARBITER_COLLISION_CNT_EN.
module top_arbiter
    import top_arbiter_pkg::*;
#(
    parameter int unsigned DEV1_CYCLES = DEF_DEV1_CYCLES,
    parameter int unsigned DEV2_CYCLES = DEF_DEV2_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en1,
    input  logic        en2,
    input  logic        req1,
    input  logic        req2,
    output logic        grant1,
    output logic        grant2,
    output logic        done1,
    output logic        done2,
    output logic        drop1,
    output logic        drop2,
    output logic [15:0] collision_cnt
);

    localparam int unsigned CNT_W = cnt_width(DEV1_CYCLES, DEV2_CYCLES);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dev_id_t          last_q, last_d;
    logic             grant1_q, grant1_d, grant2_q, grant2_d;
    logic             done1_q, done1_d, done2_q, done2_d;
    logic             pend1, pend2, elig1, elig2, take1, take2;

    top_arbiter_req u_req1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (en1),
        .req_i     (req1),
        .granted_i (grant1_q),
        .take_i    (take1),
        .pending_o (pend1),
        .drop_o    (drop1)
    );

    top_arbiter_req u_req2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (en2),
        .req_i     (req2),
        .granted_i (grant2_q),
        .take_i    (take2),
        .pending_o (pend2),
        .drop_o    (drop2)
    );

    // A pending device whose enable has just dropped is no longer a candidate.
    assign elig1 = pend1 & en1;
    assign elig2 = pend2 & en2;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        take1   = 1'b0;
        take2   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (elig1 && (!elig2 || last_q == DEV_2)) take1 = 1'b1;
                else if (elig2)                           take2 = 1'b1;
            end
            ST_SERV1: begin
                if (cnt_q == '0) begin
                    if (elig2) take2 = 1'b1;
                    else       state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SERV2: begin
                if (cnt_q == '0) begin
                    if (elig1) take1 = 1'b1;
                    else       state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (take1) begin
            state_d = ST_SERV1;
            cnt_d   = CNT_W'(DEV1_CYCLES - 1);
            last_d  = DEV_1;
        end
        if (take2) begin
            state_d = ST_SERV2;
            cnt_d   = CNT_W'(DEV2_CYCLES - 1);
            last_d  = DEV_2;
        end

        grant1_d = (state_d == ST_SERV1);
        grant2_d = (state_d == ST_SERV2);
        done1_d  = grant1_d && (cnt_d == '0);
        done2_d  = grant2_d && (cnt_d == '0);
    end

    // Device 2 counts as last served out of reset so device 1 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            last_q   <= DEV_2;
            grant1_q <= 1'b0;
            grant2_q <= 1'b0;
            done1_q  <= 1'b0;
            done2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            grant1_q <= grant1_d;
            grant2_q <= grant2_d;
            done1_q  <= done1_d;
            done2_q  <= done2_d;
        end
    end

    assign grant1 = grant1_q;
    assign grant2 = grant2_q;
    assign done1  = done1_q;
    assign done2  = done2_q;

`ifdef TOP_ARBITER_COLLISION_CNT_EN
    logic [COLL_W-1:0] coll_q, coll_d;
    logic              coll_hit;

    // Saturating count of cycles where the owner holds the resource while the other waits.
    always_comb begin
        coll_hit = (grant1_q & pend2) | (grant2_q & pend1);
        coll_d   = coll_q;
        if (coll_hit && coll_q != '1) coll_d = coll_q + COLL_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) coll_q <= '0;
        else        coll_q <= coll_d;
    end

    assign collision_cnt = coll_q;
`else
    assign collision_cnt = '0;
`endif

endmodule

// File: tb/tb_top_arbiter.sv
// Self-checking bench for top_arbiter: directed latency/arbitration scenarios
// plus randomized traffic against a cycle-level behavioural model.
module tb_top_arbiter;

    localparam int PERIOD = 20;
    localparam int N1     = 4;
    localparam int N2     = 6;

    logic        clk = 1'b0;
    logic        rst_n, en1, en2, req1, req2;
    logic        grant1, grant2, done1, done2, drop1, drop2;
    logic [15:0] collision_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: owner 0 = free, else device number; rem = service cycles left.
    int m_owner, m_rem, m_last, m_coll;
    bit m_p1, m_p2, m_g1, m_g2, m_d1, m_d2, m_dr1, m_dr2;

    top_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en1           (en1),
        .en2           (en2),
        .req1          (req1),
        .req2          (req2),
        .grant1        (grant1),
        .grant2        (grant2),
        .done1         (done1),
        .done2         (done2),
        .drop1         (drop1),
        .drop2         (drop2),
        .collision_cnt (collision_cnt)
    );

    always #(PERIOD / 2) clk = ~clk;

    task automatic model_reset();
        m_owner = 0; m_rem = 0; m_last = 2; m_coll = 0;
        m_p1 = 0; m_p2 = 0; m_g1 = 0; m_g2 = 0;
        m_d1 = 0; m_d2 = 0; m_dr1 = 0; m_dr2 = 0;
    endtask

    task automatic model_step();
        bit acc1, acc2, e1, e2;
        int nxt, other;
        m_dr1 = req1 && (!en1 || m_p1 || m_owner == 1);
        m_dr2 = req2 && (!en2 || m_p2 || m_owner == 2);
        acc1  = req1 && en1 && !m_p1 && m_owner != 1;
        acc2  = req2 && en2 && !m_p2 && m_owner != 2;
        e1    = m_p1 && en1;
        e2    = m_p2 && en2;
        if (((m_owner == 1 && m_p2) || (m_owner == 2 && m_p1)) && m_coll < 65535) m_coll++;
        m_p1 = acc1 ? 1'b1 : (en1 ? m_p1 : 1'b0);
        m_p2 = acc2 ? 1'b1 : (en2 ? m_p2 : 1'b0);
        nxt = m_owner;
        if (m_owner == 0) begin
            if (e1 && e2) nxt = (m_last == 1) ? 2 : 1;
            else if (e1)  nxt = 1;
            else if (e2)  nxt = 2;
        end else if (m_rem == 1) begin
            other = 3 - m_owner;
            nxt = ((other == 1 && e1) || (other == 2 && e2)) ? other : 0;
        end else begin
            m_rem--;
        end
        if (nxt != 0 && nxt != m_owner) begin
            m_rem  = (nxt == 1) ? N1 : N2;
            m_last = nxt;
            if (nxt == 1) m_p1 = 0; else m_p2 = 0;
        end
        m_owner = nxt;
        m_g1 = (m_owner == 1);
        m_g2 = (m_owner == 2);
        m_d1 = m_g1 && m_rem == 1;
        m_d2 = m_g2 && m_rem == 1;
    endtask

    // One clock edge with the given request pulses; returns 1 time unit after the edge.
    task automatic tick(input bit r1, input bit r2);
        req1 = r1;
        req2 = r2;
        @(posedge clk);
        model_step();
        #1;
        req1 = 1'b0;
        req2 = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en1 = 1'b1; en2 = 1'b1; req1 = 1'b0; req2 = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en1 = 1'b1; en2 = 1'b1; req1 = 1'b0; req2 = 1'b0;
        model_reset();
        #3;
        n_cmp++;
        if ({grant1, grant2, done1, done2, drop1, drop2, collision_cnt} !== 22'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b/%0h required all zero",
                     {grant1, grant2, done1, done2, drop1, drop2}, collision_cnt);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1'b0, 1'b0);
        n_cmp++;
        if ({grant1, grant2, done1, done2, drop1, drop2, collision_cnt} !== 22'd0) begin
            n_bad++;
            $display("FAIL idle_after_reset: got %b/%0h required all zero",
                     {grant1, grant2, done1, done2, drop1, drop2}, collision_cnt);
        end
    endtask

    task automatic test_uncontended();
        bit eg, ed;
        do_reset();
        for (int e = 0; e <= 6; e++) begin
            tick(e == 0, 1'b0);
            eg = (e >= 1 && e <= 4);
            ed = (e == 4);
            n_cmp++;
            if ({grant1, done1, grant2, done2} !== {eg, ed, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL uncont_dev1 edge %0d: got g1/d1/g2/d2=%b required %b",
                         e, {grant1, done1, grant2, done2}, {eg, ed, 2'b00});
            end
        end
        for (int e = 0; e <= 8; e++) begin
            tick(1'b0, e == 0);
            eg = (e >= 1 && e <= 6);
            ed = (e == 6);
            n_cmp++;
            if ({grant2, done2, grant1, done1} !== {eg, ed, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL uncont_dev2 edge %0d: got g2/d2/g1/d1=%b required %b",
                         e, {grant2, done2, grant1, done1}, {eg, ed, 2'b00});
            end
        end
    endtask

    task automatic test_simultaneous();
        bit eg1, eg2, ed1, ed2;
        logic [15:0] exp_coll;
        do_reset();
        for (int e = 0; e <= 11; e++) begin
            tick(e == 0, e == 0);
            if (e == 5) begin
`ifdef TOP_ARBITER_COLLISION_CNT_EN
                exp_coll = 16'd4;
`else
                exp_coll = 16'd0;
`endif
                n_cmp++;
                if (collision_cnt !== exp_coll) begin
                    n_bad++;
                    $display("FAIL collision_cnt: got %0d required %0d", collision_cnt, exp_coll);
                end
            end
            eg1 = (e >= 1 && e <= 4);  ed1 = (e == 4);
            eg2 = (e >= 5 && e <= 10); ed2 = (e == 10);
            n_cmp++;
            if ({grant1, grant2, done1, done2} !== {eg1, eg2, ed1, ed2}) begin
                n_bad++;
                $display("FAIL tie_first edge %0d: got g1/g2/d1/d2=%b required %b",
                         e, {grant1, grant2, done1, done2}, {eg1, eg2, ed1, ed2});
            end
        end
        // A solo device-1 service makes device 1 the last served, so the next tie goes to device 2.
        for (int e = 0; e <= 5; e++) tick(e == 0, 1'b0);
        for (int e = 0; e <= 11; e++) begin
            tick(e == 0, e == 0);
            eg2 = (e >= 1 && e <= 6);  ed2 = (e == 6);
            eg1 = (e >= 7 && e <= 10); ed1 = (e == 10);
            n_cmp++;
            if ({grant1, grant2, done1, done2} !== {eg1, eg2, ed1, ed2}) begin
                n_bad++;
                $display("FAIL tie_second edge %0d: got g1/g2/d1/d2=%b required %b",
                         e, {grant1, grant2, done1, done2}, {eg1, eg2, ed1, ed2});
            end
        end
    endtask

    task automatic test_sweep();
        int done_e, exp_e;
        bit both;
        for (int o = 0; o <= 16; o++) begin
            do_reset();
            done_e = -1;
            both   = 1'b0;
            for (int e = 0; e <= 30; e++) begin
                tick(e == 0, e == o);
                if (grant1 && grant2) both = 1'b1;
                if (done2 && done_e < 0) done_e = e;
            end
            exp_e = ((o + 1 > 5) ? o + 1 : 5) + N2 - 1;
            n_cmp++;
            if (done_e !== exp_e) begin
                n_bad++;
                $display("FAIL sweep_done2 offset %0d: got edge %0d required edge %0d", o, done_e, exp_e);
            end
            n_cmp++;
            if (both !== 1'b0) begin
                n_bad++;
                $display("FAIL sweep_exclusive offset %0d: got both grants high required never", o);
            end
        end
    endtask

    task automatic test_drop();
        int n_done, n_drop;
        do_reset();
        n_done = 0;
        n_drop = 0;
        for (int e = 0; e <= 8; e++) begin
            tick(e == 0 || e == 2, 1'b0);
            if (done1) n_done++;
            if (drop1) n_drop++;
            if (e == 2) begin
                n_cmp++;
                if (drop1 !== 1'b1) begin
                    n_bad++;
                    $display("FAIL drop1_pulse: got %b required 1", drop1);
                end
            end
        end
        n_cmp++;
        if (n_done !== 1 || n_drop !== 1) begin
            n_bad++;
            $display("FAIL drop_counts: got done1=%0d drop1=%0d required 1 and 1", n_done, n_drop);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int e = 0; e <= 3; e++) tick(1'b0, e == 0);
        n_cmp++;
        if (grant2 !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_serv2_grant: got %b required 1", grant2);
        end
        #5;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({grant1, grant2, done1, done2, drop1, drop2, collision_cnt} !== 22'd0) begin
            n_bad++;
            $display("FAIL async_reset: got %b/%0h required all zero",
                     {grant1, grant2, done1, done2, drop1, drop2}, collision_cnt);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int e = 0; e <= 5; e++) begin
            tick(e == 0, 1'b0);
            n_cmp++;
            if ({grant1, done1} !== {e >= 1 && e <= 4, e == 4}) begin
                n_bad++;
                $display("FAIL post_reset_dev1 edge %0d: got g1/d1=%b required %b",
                         e, {grant1, done1}, {e >= 1 && e <= 4, e == 4});
            end
        end
    endtask

    task automatic test_disable();
        bit saw_g2;
        do_reset();
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        en2 = 1'b0;
        saw_g2 = 1'b0;
        for (int e = 2; e <= 8; e++) begin
            tick(1'b0, 1'b0);
            if (grant2) saw_g2 = 1'b1;
            if (e == 5) begin
                n_cmp++;
                if ({grant1, grant2} !== 2'b00) begin
                    n_bad++;
                    $display("FAIL disable_idle: got g1/g2=%b required 00", {grant1, grant2});
                end
            end
        end
        en2 = 1'b1;
        for (int e = 0; e < 4; e++) begin
            tick(1'b0, 1'b0);
            if (grant2) saw_g2 = 1'b1;
        end
        n_cmp++;
        if (saw_g2 !== 1'b0) begin
            n_bad++;
            $display("FAIL disable_no_grant2: got grant2 seen required never");
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_coll;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            en1 = ($urandom_range(0, 9) != 0);
            en2 = ($urandom_range(0, 9) != 0);
            tick($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            n_cmp++;
            if ({grant1, grant2, done1, done2, drop1, drop2} !== {m_g1, m_g2, m_d1, m_d2, m_dr1, m_dr2}) begin
                n_bad++;
                $display("FAIL random_outputs cycle %0d: got g1g2d1d2x1x2=%b required %b", i,
                         {grant1, grant2, done1, done2, drop1, drop2},
                         {m_g1, m_g2, m_d1, m_d2, m_dr1, m_dr2});
            end
`ifdef TOP_ARBITER_COLLISION_CNT_EN
            exp_coll = 16'(m_coll);
`else
            exp_coll = 16'd0;
`endif
            n_cmp++;
            if (collision_cnt !== exp_coll) begin
                n_bad++;
                $display("FAIL random_collision cycle %0d: got %0d required %0d", i, collision_cnt, exp_coll);
            end
            n_cmp++;
            if ((grant1 & grant2) !== 1'b0) begin
                n_bad++;
                $display("FAIL random_exclusive cycle %0d: got both grants high required at most one", i);
            end
        end
        en1 = 1'b1;
        en2 = 1'b1;
    endtask

    initial begin
        test_reset();
        test_uncontended();
        test_simultaneous();
        test_sweep();
        test_drop();
        test_reset_mid();
        test_disable();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
